// File: rtl/ps2_char_source.sv
// PS/2 keyboard receiver: synchronizes and filters the pins, deframes 11-bit frames,
// tracks E0/F0 prefixes and emits one newchar/char strobe per complete key code.
module ps2_char_source #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 20000,
   parameter int unsigned CNT_W      = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic        newchar,
   output logic [15:0] char,
   output logic        frame_err
);

   localparam int unsigned FCNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned BIT_W  = 4;
   localparam int unsigned SHR_W  = 10;

   typedef enum logic [1:0] {IDLE, RECV, CHECK} stateT;

   logic [1:0]        clkSync, dataSync;
   logic [FCNT_W-1:0] filtCnt;
   logic              filtClk, filtClkD;
   logic              fallEvt, dataBit;

   stateT             state, stateNxt;
   logic [BIT_W-1:0]  bitCnt, bitCntNxt;
   logic [SHR_W-1:0]  shiftReg, shiftNxt;
   logic [CNT_W-1:0]  toCnt, toNxt;
   logic              ext, extNxt, brk, brkNxt;
   logic              newcharNxt, frameErrNxt;
   logic [15:0]       charNxt;
   logic [7:0]        rxByte;

   // Two-flop synchronizers plus a run-length glitch filter on the PS/2 clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkSync  <= 2'b11;
         dataSync <= 2'b11;
         filtCnt  <= '0;
         filtClk  <= 1'b1;
         filtClkD <= 1'b1;
      end else begin
         clkSync  <= {clkSync[0], ps2_clk};
         dataSync <= {dataSync[0], ps2_data};
         filtClkD <= filtClk;
         if (clkSync[1] == filtClk) begin
            filtCnt <= '0;
         end else if (filtCnt == FCNT_W'(FILTER_LEN - 1)) begin
            filtClk <= clkSync[1];
            filtCnt <= '0;
         end else begin
            filtCnt <= filtCnt + FCNT_W'(1);
         end
      end
   end

   assign fallEvt = filtClkD & ~filtClk;
   assign dataBit = dataSync[1];
   assign rxByte  = shiftReg[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bitCnt    <= '0;
         shiftReg  <= '0;
         toCnt     <= '0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         newchar   <= 1'b0;
         char      <= 16'h0000;
         frame_err <= 1'b0;
      end else begin
         state     <= stateNxt;
         bitCnt    <= bitCntNxt;
         shiftReg  <= shiftNxt;
         toCnt     <= toNxt;
         ext       <= extNxt;
         brk       <= brkNxt;
         newchar   <= newcharNxt;
         char      <= charNxt;
         frame_err <= frameErrNxt;
      end
   end

   // Frame deserializer, frame check and prefix tracking
   always_comb begin
      stateNxt    = state;
      bitCntNxt   = bitCnt;
      shiftNxt    = shiftReg;
      toNxt       = toCnt;
      extNxt      = ext;
      brkNxt      = brk;
      newcharNxt  = 1'b0;
      charNxt     = char;
      frameErrNxt = 1'b0;
      case (state)
         IDLE: begin
            if (fallEvt) begin
               if (!dataBit) begin
                  stateNxt  = RECV;
                  bitCntNxt = '0;
                  toNxt     = '0;
               end else begin
                  frameErrNxt = 1'b1;
               end
            end
         end
         RECV: begin
            if (fallEvt) begin
               shiftNxt  = {dataBit, shiftReg[SHR_W-1:1]};
               toNxt     = '0;
               bitCntNxt = bitCnt + BIT_W'(1);
               if (bitCnt == BIT_W'(SHR_W - 1)) begin
                  stateNxt = CHECK;
               end
            end else if (toCnt == CNT_W'(TIMEOUT - 1)) begin
               stateNxt    = IDLE;
               bitCntNxt   = '0;
               shiftNxt    = '0;
               toNxt       = '0;
               extNxt      = 1'b0;
               brkNxt      = 1'b0;
               frameErrNxt = 1'b1;
            end else begin
               toNxt = toCnt + CNT_W'(1);
            end
         end
         CHECK: begin
            stateNxt  = IDLE;
            bitCntNxt = '0;
            // shiftReg[8] is parity (odd over data+parity), shiftReg[9] is stop
            if (!(^shiftReg[8:0]) || !shiftReg[9]) begin
               frameErrNxt = 1'b1;
               extNxt      = 1'b0;
               brkNxt      = 1'b0;
            end else if (rxByte == 8'hE0) begin
               extNxt = 1'b1;
            end else if (rxByte == 8'hF0) begin
               brkNxt = 1'b1;
            end else begin
               charNxt    = {brk, ext, 6'b000000, rxByte};
               newcharNxt = 1'b1;
               extNxt     = 1'b0;
               brkNxt     = 1'b0;
            end
         end
         default: begin
            stateNxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_char_source.sv
// Bench for ps2_char_source: drives PS/2 frames and compares every cycle against a
// byte-level model of prefix handling and expected strobes.
`timescale 1ns/1ps
module tb_ps2_char_source;

   localparam int unsigned FILTER_LEN = 8;
   localparam int unsigned TIMEOUT    = 20000;
   localparam int unsigned CNT_W      = 15;
   localparam int unsigned HALF       = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2Clk = 1'b1;
   logic        ps2Data = 1'b1;
   logic        newchar, frameErr;
   logic [15:0] charOut;

   int nChecks = 0;
   int nFails  = 0;

   // Expected strobes in order: bit16=1 means frame_err, else newchar with char=[15:0]
   logic [16:0] expQ[$];
   logic [15:0] modelChar = 16'h0000;
   logic        mExt = 1'b0;
   logic        mBrk = 1'b0;

   ps2_char_source #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
      .newchar(newchar), .char(charOut), .frame_err(frameErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Byte-level model: what the receiver must produce for a completed frame
   task automatic modelFrame(input logic [7:0] b, input logic p, input logic stop);
      if (((^b) ^ p) !== 1'b1 || stop !== 1'b1) begin
         expQ.push_back({1'b1, 16'h0000});
         mExt = 1'b0;
         mBrk = 1'b0;
      end else if (b == 8'hE0) begin
         mExt = 1'b1;
      end else if (b == 8'hF0) begin
         mBrk = 1'b1;
      end else begin
         expQ.push_back({1'b0, mBrk, mExt, 6'b000000, b});
         mExt = 1'b0;
         mBrk = 1'b0;
      end
   endtask

   task automatic waitClks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendBit(input logic b, input bit glitch);
      ps2Data = b;
      if (glitch) begin
         waitClks(HALF / 2);
         ps2Clk = 1'b0;
         waitClks(3);
         ps2Clk = 1'b1;
         waitClks(HALF / 2);
      end else begin
         waitClks(HALF);
      end
      ps2Clk = 1'b0;
      waitClks(HALF);
      ps2Clk = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] b, input bit badParity = 1'b0, input bit glitch = 1'b0);
      logic p;
      p = (~^b) ^ badParity;
      sendBit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i], glitch && (i == 3));
      sendBit(p, 1'b0);
      modelFrame(b, p, 1'b1);
      sendBit(1'b1, 1'b0);
      waitClks(30);
      check("strobe_drain", 32'(expQ.size()), 32'd0);
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      logic [16:0] ev;
      if (rst) begin
         check("rst_newchar", 32'(newchar), 32'd0);
         check("rst_frame_err", 32'(frameErr), 32'd0);
         check("rst_char", 32'(charOut), 32'd0);
      end else begin
         check("strobe_exclusive", 32'(newchar & frameErr), 32'd0);
         if (newchar || frameErr) begin
            check("strobe_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
               ev = expQ.pop_front();
               check("strobe_kind_err", 32'(frameErr), 32'(ev[16]));
               if (newchar) begin
                  check("char_value", 32'(charOut), 32'(ev[15:0]));
                  if (!ev[16]) modelChar = ev[15:0];
               end
            end
         end else begin
            check("char_hold", 32'(charOut), 32'(modelChar));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected queue size %0d", expQ.size());
      $fatal(1, "watchdog");
   end

   initial begin
      waitClks(3);
      rst = 1'b0;
      waitClks(5);
      check("reset_char", 32'(charOut), 32'h0000);

      sendFrame(8'h1C);
      check("make_1C", 32'(charOut), 32'h001C);

      sendFrame(8'hF0);
      check("break_prefix_no_emit", 32'(charOut), 32'h001C);
      sendFrame(8'h1C);
      check("break_1C", 32'(charOut), 32'h801C);
      sendFrame(8'h1C);
      check("flags_cleared_1C", 32'(charOut), 32'h001C);

      sendFrame(8'hE0);
      sendFrame(8'hF0);
      sendFrame(8'h75);
      check("ext_break_75", 32'(charOut), 32'hC075);
      sendFrame(8'hE0);
      sendFrame(8'h75);
      check("ext_make_75", 32'(charOut), 32'h4075);

      sendFrame(8'h1C, 1'b1);
      check("parity_err_char_held", 32'(charOut), 32'h4075);
      sendFrame(8'h2B);
      check("after_parity_2B", 32'(charOut), 32'h002B);

      sendFrame(8'h5A, 1'b0, 1'b1);
      check("glitch_ignored_5A", 32'(charOut), 32'h005A);

      // Extended prefix, then an abandoned frame that must time out and drop the prefix
      sendFrame(8'hE0);
      sendBit(1'b0, 1'b0);
      sendBit(1'b0, 1'b0);
      sendBit(1'b0, 1'b0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b1, 1'b0);
      expQ.push_back({1'b1, 16'h0000});
      mExt = 1'b0;
      mBrk = 1'b0;
      waitClks(TIMEOUT + 10 + HALF);
      check("timeout_err_seen", 32'(expQ.size()), 32'd0);
      sendFrame(8'h1C);
      check("after_timeout_1C", 32'(charOut), 32'h001C);

      // Asynchronous reset in the middle of a frame after an extended prefix
      sendFrame(8'hE0);
      sendBit(1'b0, 1'b0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      expQ.delete();
      modelChar = 16'h0000;
      mExt = 1'b0;
      mBrk = 1'b0;
      #1;
      check("async_rst_char", 32'(charOut), 32'h0000);
      check("async_rst_newchar", 32'(newchar), 32'd0);
      waitClks(3);
      rst = 1'b0;
      waitClks(5);
      sendFrame(8'h75);
      check("after_reset_75", 32'(charOut), 32'h0075);

      waitClks(20);
      check("final_drain", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
